colour_reporter: RTL and testbench

- Downstream consumer of the colour-sensor detector stage.
- Takes the detector's one-hot red/green/blue outputs and filters them for stability.
- Latches each newly accepted colour and reports it as a 4-byte ASCII message over a UART 8N1 transmitter to the telemetry link.
- Also exposes the accepted colour and a running event count for on-board status logic.

---
 rtl/colour_pkg.sv | 31 +++
 rtl/colour_reporter_if.sv | 21 ++
 rtl/uart_tx_byte.sv | 97 +++++++++
 rtl/colour_reporter.sv | 153 +++++++++++++++
 tb/tb_colour_reporter.sv | 290 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/colour_pkg.sv
// colour_pkg: colour encodings and ASCII bytes for the colour report link.
// Shared by the reporter top level and its bench-facing interface users.
package colour_pkg;

  typedef logic [1:0] colour_t;

  localparam colour_t COL_NONE  = 2'd0;
  localparam colour_t COL_RED   = 2'd1;
  localparam colour_t COL_GREEN = 2'd2;
  localparam colour_t COL_BLUE  = 2'd3;

  localparam logic [7:0] ASC_C     = 8'h43;
  localparam logic [7:0] ASC_COLON = 8'h3A;
  localparam logic [7:0] ASC_LF    = 8'h0A;
  localparam logic [7:0] ASC_R     = 8'h52;
  localparam logic [7:0] ASC_G     = 8'h47;
  localparam logic [7:0] ASC_B     = 8'h42;
  localparam logic [7:0] ASC_N     = 8'h4E;

  function automatic logic [7:0] colour_letter(input colour_t c);
    logic [7:0] l;
    case (c)
      COL_RED:   l = ASC_R;
      COL_GREEN: l = ASC_G;
      COL_BLUE:  l = ASC_B;
      default:   l = ASC_N;
    endcase
    return l;
  endfunction

endpackage

// File: rtl/colour_reporter_if.sv
// colour_reporter_if: detector LEDs in; tx, busy, colour_code, event_count out.
// master = detector/status side, slave = colour_reporter.
interface colour_reporter_if;
  logic       red_led;
  logic       green_led;
  logic       blue_led;
  logic       tx;
  logic       busy;
  logic [1:0] colour_code;
  logic [7:0] event_count;

  modport master (
    output red_led, green_led, blue_led,
    input  tx, busy, colour_code, event_count
  );

  modport slave (
    input  red_led, green_led, blue_led,
    output tx, busy, colour_code, event_count
  );
endinterface

// File: rtl/uart_tx_byte.sv
// uart_tx_byte: 8N1 byte transmitter. In: clk, rst_n, start, data[7:0].
// Out: tx (idle high), done (pulse in last stop-bit cycle; start accepted then).
module uart_tx_byte #(
  parameter int unsigned CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] data,
  output logic       tx,
  output logic       done
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  localparam logic [15:0] LAST = 16'(CLKS_PER_BIT - 1);

  logic [1:0]  state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  sh_q, sh_d;
  logic        tx_q, tx_d;
  logic        last;

  assign last = (cnt_q == LAST);
  assign done = (state_q == S_STOP) && last;
  assign tx   = tx_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = last ? 16'd0 : cnt_q + 16'd1;
    bit_d   = bit_q;
    sh_d    = sh_q;
    tx_d    = tx_q;
    unique case (state_q)
      S_IDLE: begin
        cnt_d = 16'd0;
        if (start) begin
          state_d = S_START;
          sh_d    = data;
          tx_d    = 1'b0;
        end
      end
      S_START: begin
        if (last) begin
          state_d = S_DATA;
          bit_d   = 3'd0;
          tx_d    = sh_q[0];
        end
      end
      S_DATA: begin
        if (last) begin
          if (bit_q == 3'd7) begin
            state_d = S_STOP;
            tx_d    = 1'b1;
          end else begin
            bit_d = bit_q + 3'd1;
            sh_d  = sh_q >> 1;
            tx_d  = sh_q[1];
          end
        end
      end
      S_STOP: begin
        // A start here chains the next byte with no idle gap.
        if (last) begin
          if (start) begin
            state_d = S_START;
            sh_d    = data;
            tx_d    = 1'b0;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= 16'd0;
      bit_q   <= 3'd0;
      sh_q    <= 8'd0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
      tx_q    <= tx_d;
    end
  end

endmodule

// File: rtl/colour_reporter.sv
// colour_reporter: decode+filter LEDs, report accepted colour as "C:x\n" 8N1.
// Ports: clk, rst_n, bus (slave). Option macro: COLOUR_REPORTER_NONE_EN.
module colour_reporter
  import colour_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT  = 434,
  parameter int unsigned STABLE_CYCLES = 50000
) (
  input logic               clk,
  input logic               rst_n,
  colour_reporter_if.slave  bus
);

  localparam logic [23:0] STABLE = 24'(STABLE_CYCLES);
  localparam logic [23:0] ACC_AT = 24'(STABLE_CYCLES - 1);

  colour_t     dec;
  colour_t     cand_q, cand_d;
  logic [23:0] cnt_q, cnt_d;
  colour_t     acc_q, acc_d;
  logic        pend_q, pend_d;
  colour_t     pcol_q, pcol_d;
  logic        busy_q, busy_d;
  logic [1:0]  idx_q, idx_d;
  logic [7:0]  letter_q, letter_d;
  logic [7:0]  evt_q, evt_d;
  logic        none_ok, accept;
  logic        eom, go_idle, go_eom, go;
  colour_t     go_col;
  logic        u_start, u_done, u_tx;
  logic [1:0]  nxt_idx;
  logic [7:0]  u_data;

  always_comb begin
    dec = COL_NONE;
    case ({bus.red_led, bus.green_led, bus.blue_led})
      3'b100:  dec = COL_RED;
      3'b010:  dec = COL_GREEN;
      3'b001:  dec = COL_BLUE;
      default: dec = COL_NONE;
    endcase
  end

  always_comb begin
    cand_d = cand_q;
    cnt_d  = cnt_q;
    if (dec != cand_q) begin
      cand_d = dec;
      cnt_d  = 24'd0;
    end else if (cnt_q != STABLE) begin
      cnt_d = cnt_q + 24'd1;
    end
  end

`ifdef COLOUR_REPORTER_NONE_EN
  assign none_ok = 1'b1;
`else
  assign none_ok = (cand_d != COL_NONE);
`endif

  // cnt_d counts cycles held beyond the first; it passes ACC_AT once per run.
  assign accept = (cnt_d == ACC_AT) && (cand_d != acc_q) && none_ok;

  assign eom     = busy_q && u_done && (idx_q == 2'd3);
  assign go_idle = !busy_q && pend_q;
  // At end of message a same-cycle acceptance bypasses the pending slot.
  assign go_eom  = eom && (pend_q || accept);
  assign go      = go_idle || go_eom;
  assign go_col  = (go_eom && accept) ? cand_d : pcol_q;

  always_comb begin
    acc_d    = acc_q;
    pend_d   = pend_q;
    pcol_d   = pcol_q;
    busy_d   = busy_q;
    idx_d    = idx_q;
    letter_d = letter_q;
    evt_d    = evt_q;
    if (accept) acc_d = cand_d;
    if (go_eom) begin
      pend_d = 1'b0;
    end else if (accept) begin
      pend_d = 1'b1;
      pcol_d = cand_d;
    end else if (go_idle) begin
      pend_d = 1'b0;
    end
    if (go) begin
      busy_d   = 1'b1;
      idx_d    = 2'd0;
      letter_d = colour_letter(go_col);
      evt_d    = evt_q + 8'd1;
    end else if (eom) begin
      busy_d = 1'b0;
    end else if (busy_q && u_done) begin
      idx_d = idx_q + 2'd1;
    end
  end

  assign nxt_idx = go ? 2'd0 : idx_q + 2'd1;
  assign u_start = go || (busy_q && u_done && (idx_q != 2'd3));

  always_comb begin
    u_data = ASC_LF;
    unique case (nxt_idx)
      2'd0: u_data = ASC_C;
      2'd1: u_data = ASC_COLON;
      2'd2: u_data = letter_q;
      2'd3: u_data = ASC_LF;
    endcase
  end

  uart_tx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_tx_byte (
    .clk   (clk),
    .rst_n (rst_n),
    .start (u_start),
    .data  (u_data),
    .tx    (u_tx),
    .done  (u_done)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cand_q   <= COL_NONE;
      cnt_q    <= 24'd0;
      acc_q    <= COL_NONE;
      pend_q   <= 1'b0;
      pcol_q   <= COL_NONE;
      busy_q   <= 1'b0;
      idx_q    <= 2'd0;
      letter_q <= ASC_N;
      evt_q    <= 8'd0;
    end else begin
      cand_q   <= cand_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      pend_q   <= pend_d;
      pcol_q   <= pcol_d;
      busy_q   <= busy_d;
      idx_q    <= idx_d;
      letter_q <= letter_d;
      evt_q    <= evt_d;
    end
  end

  assign bus.tx          = u_tx;
  assign bus.busy        = busy_q;
  assign bus.colour_code = acc_q;
  assign bus.event_count = evt_q;

endmodule

// File: tb/tb_colour_reporter.sv
// tb_colour_reporter: directed + random stimulus against a timeline model.
// DUT built with CLKS_PER_BIT=4, STABLE_CYCLES=8.
module tb_colour_reporter;

  localparam int CPB = 4;
  localparam int S   = 8;
`ifdef COLOUR_REPORTER_NONE_EN
  localparam bit NONE_OK = 1'b1;
`else
  localparam bit NONE_OK = 1'b0;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  colour_reporter_if bus();

  colour_reporter #(
    .CLKS_PER_BIT  (CPB),
    .STABLE_CYCLES (S)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [1:0] dec3(input logic r, g, b);
    int n;
    n = int'(r) + int'(g) + int'(b);
    if (n != 1) return 2'd0;
    if (r) return 2'd1;
    if (g) return 2'd2;
    return 2'd3;
  endfunction

  function automatic logic [7:0] let_of(input logic [1:0] c);
    logic [7:0] t[4];
    t = '{8'h4E, 8'h52, 8'h47, 8'h42};
    return t[c];
  endfunction

  // Model: expected tx level per upcoming cycle, front = current cycle.
  bit         m_q[$];
  logic [1:0] m_cc   = 2'd0;
  logic [1:0] m_prev = 2'd0;
  logic [1:0] m_pcol = 2'd0;
  bit         m_pend = 1'b0;
  int         m_run  = 0;
  logic [7:0] m_ec   = 8'd0;

  task automatic push_msg(input logic [1:0] c);
    logic [7:0] by[4];
    by = '{8'h43, 8'h3A, let_of(c), 8'h0A};
    for (int b = 0; b < 4; b++) begin
      for (int k = 0; k < CPB; k++) m_q.push_back(1'b0);
      for (int i = 0; i < 8; i++)
        for (int k = 0; k < CPB; k++) m_q.push_back(by[b][i]);
      for (int k = 0; k < CPB; k++) m_q.push_back(1'b1);
    end
    m_ec = m_ec + 8'd1;
  endtask

  always @(posedge clk or negedge rst_n) begin : model
    logic [1:0] d;
    bit acc, was, used;
    if (!rst_n) begin
      m_q.delete();
      m_cc = 0; m_prev = 0; m_pcol = 0;
      m_pend = 0; m_run = 0; m_ec = 0;
    end else begin
      d = dec3(bus.red_led, bus.green_led, bus.blue_led);
      if (d == m_prev) m_run++;
      else begin
        m_run  = 1;
        m_prev = d;
      end
      acc  = (m_run == S) && (d != m_cc) && (NONE_OK || d != 2'd0);
      if (acc) m_cc = d;
      used = 1'b0;
      was  = (m_q.size() != 0);
      if (was) void'(m_q.pop_front());
      if (m_q.size() == 0) begin
        if (was && (acc || m_pend)) begin
          push_msg(acc ? d : m_pcol);
          m_pend = 1'b0;
          used   = acc;
        end else if (!was && m_pend) begin
          push_msg(m_pcol);
          m_pend = 1'b0;
        end
      end
      if (acc && !used) begin
        m_pend = 1'b1;
        m_pcol = d;
      end
    end
  end

  always @(negedge clk) begin
    chk("m_tx", bus.tx, (m_q.size() != 0) ? m_q[0] : 1'b1);
    chk("m_busy", bus.busy, m_q.size() != 0);
    chk("m_code", bus.colour_code, m_cc);
    chk("m_count", bus.event_count, m_ec);
  end

  task automatic set_leds(input logic [2:0] p);
    {bus.red_led, bus.green_led, bus.blue_led} = p;
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 rst_n = 1'b0;
    set_leds(3'b000);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;
  endtask

  logic rx_s[160];

  task automatic rx_check(input string pfx, input logic [7:0] lt);
    int n;
    logic [7:0] e[4];
    logic [7:0] got;
    n = 0;
    while (bus.tx !== 1'b0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk({pfx, "_start_seen"}, n < 200, 1);
    for (int i = 0; i < 160; i++) begin
      rx_s[i] = bus.tx;
      if (i < 159) @(negedge clk);
    end
    e = '{8'h43, 8'h3A, lt, 8'h0A};
    for (int b = 0; b < 4; b++) begin
      for (int k = 0; k < 8; k++) got[k] = rx_s[40*b + 4 + 4*k];
      chk($sformatf("%s_byte%0d", pfx, b), got, e[b]);
      chk($sformatf("%s_stop%0d", pfx, b), rx_s[40*b + 36], 1);
    end
  endtask

  logic cap[400];

  initial begin : stim
    int n;
    logic [7:0] l;
    set_leds(3'b000);
    @(negedge clk);
    chk("rst_tx", bus.tx, 1);
    chk("rst_busy", bus.busy, 0);
    chk("rst_code", bus.colour_code, 0);
    chk("rst_count", bus.event_count, 0);
    #2 rst_n = 1'b1;

    // 1: red held; acceptance after 8 cycles, then one message.
    do_reset();
    @(posedge clk);
    #1 set_leds(3'b100);
    repeat (7) @(posedge clk);
    @(negedge clk);
    chk("t1_code_early", bus.colour_code, 0);
    @(negedge clk);
    chk("t1_code", bus.colour_code, 1);
    chk("t1_busy_pre", bus.busy, 0);
    @(negedge clk);
    chk("t1_busy", bus.busy, 1);
    chk("t1_startbit", bus.tx, 0);
    rx_check("t1", 8'h52);
    @(negedge clk);
    chk("t1_busy_end", bus.busy, 0);
    chk("t1_count", bus.event_count, 1);

    // 2: green for only 7 cycles.
    do_reset();
    @(posedge clk);
    #1 set_leds(3'b010);
    repeat (7) @(posedge clk);
    #1 set_leds(3'b000);
    repeat (30) @(negedge clk);
    chk("t2_count", bus.event_count, 0);
    chk("t2_tx", bus.tx, 1);
    chk("t2_code", bus.colour_code, 0);

    // 3: red+blue decodes to NONE.
    do_reset();
    set_leds(3'b101);
    repeat (50) @(negedge clk);
    chk("t3_count", bus.event_count, NONE_OK ? 0 : 0);
    chk("t3_busy", bus.busy, 0);

    // 4: blue then green during a red message, newest wins, zero gap.
    do_reset();
    set_leds(3'b100);
    n = 0;
    while (!bus.busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("t4_start", n < 100, 1);
    n = 0;
    while (bus.busy && n < 1000) begin
      if (n < 400) cap[n] = bus.tx;
      if (n == 20) set_leds(3'b001);
      if (n == 50) set_leds(3'b010);
      @(negedge clk);
      n++;
    end
    chk("t4_busy_len", n, 320);
    chk("t4_count", bus.event_count, 2);
    chk("t4_code", bus.colour_code, 2);
    for (int k = 0; k < 8; k++) l[k] = cap[160 + 80 + 4 + 4*k];
    chk("t4_letter2", l, 8'h47);

    // 5: reset in byte 2, then a fresh message.
    do_reset();
    set_leds(3'b100);
    n = 0;
    while (!bus.busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("t5_start", n < 100, 1);
    repeat (90) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_rst_tx", bus.tx, 1);
    chk("t5_rst_busy", bus.busy, 0);
    chk("t5_rst_code", bus.colour_code, 0);
    chk("t5_rst_count", bus.event_count, 0);
    set_leds(3'b000);
    @(negedge clk);
    #2 rst_n = 1'b1;
    set_leds(3'b100);
    rx_check("t5", 8'h52);
    @(negedge clk);
    chk("t5_count", bus.event_count, 1);

`ifdef COLOUR_REPORTER_NONE_EN
    // 6: blue, then stable all-low reports 'N'.
    do_reset();
    set_leds(3'b001);
    repeat (200) @(negedge clk);
    set_leds(3'b000);
    repeat (200) @(negedge clk);
    chk("t6_code", bus.colour_code, 0);
    chk("t6_count", bus.event_count, 2);
`else
    // 6: red -> none -> red gives a single message.
    do_reset();
    set_leds(3'b100);
    repeat (200) @(negedge clk);
    set_leds(3'b000);
    repeat (50) @(negedge clk);
    set_leds(3'b100);
    repeat (200) @(negedge clk);
    chk("t6_code", bus.colour_code, 1);
    chk("t6_count", bus.event_count, 1);
`endif

    // Random patterns with short and long holds.
    do_reset();
    for (int s = 0; s < 150; s++) begin
      set_leds(3'($urandom_range(0, 7)));
      if ($urandom_range(0, 3) == 0) n = $urandom_range(8, 200);
      else n = $urandom_range(1, 12);
      repeat (n) @(negedge clk);
      if ($urandom_range(0, 60) == 0) do_reset();
    end
    set_leds(3'b000);
    repeat (400) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
